// File: rtl/simplebus_burst_follower.sv
// simplebus_burst_follower
// Memory-side follower for the simplebus leader/follower protocol with
// configurable bus/address widths, programmable read wait states and
// incrementing multi-beat bursts. Tri-state drives are split into out/oe pairs.
module simplebus_burst_follower #(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned BURST_W      = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 read,
    input  logic [BUS_WIDTH-1:0] address,
    input  logic [BURST_W-1:0]   burst_len,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 dv_in,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 data_oe,
    output logic                 dv_out,
    output logic                 dv_oe,
    output logic                 busy
);

    localparam int unsigned NPH   = ADDR_WIDTH / BUS_WIDTH;
    localparam int unsigned PH_W  = (NPH > 1) ? $clog2(NPH) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(NPH - 1);
    localparam logic [3:0]      LAT_LOAD = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RWAIT,
        S_RDATA,
        S_WDATA
    } state_t;

    state_t                  state_q;
    state_t                  dispatch_state;
    logic                    dispatch_rd;
    logic [PH_W-1:0]         phase_q;
    logic [3:0]              lat_q;
    logic [BURST_W-1:0]      beat_q;
    logic [BURST_W-1:0]      len_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_shift;
    logic                    busy_q;
    logic                    data_oe_q;
    logic                    dv_oe_q;
    logic                    dv_out_q;
    logic                    mem_we;
    logic [BUS_WIDTH-1:0]    mem_q [DEPTH];

    // Next state once the final address chunk has been captured, decided by read
    always_comb begin
        dispatch_state = S_WDATA;
        if (read) begin
            dispatch_state = (READ_LATENCY > 0) ? S_RWAIT : S_RDATA;
        end
        dispatch_rd = (dispatch_state == S_RDATA);
    end

    // Address chunks arrive MS first: shift the partial address up and append
    assign addr_shift = (addr_q << BUS_WIDTH) | ADDR_WIDTH'(address);

    // A write beat on the reset edge must not land in memory
    assign mem_we = (state_q == S_WDATA) && dv_in && !reset;

    // Protocol FSM with registered bus-drive outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            lat_q     <= '0;
            beat_q    <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            data_oe_q <= 1'b0;
            dv_oe_q   <= 1'b0;
            dv_out_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= ADDR_WIDTH'(address);
                        len_q  <= burst_len;
                        beat_q <= '0;
                        busy_q <= 1'b1;
                        if (NPH == 1) begin
                            // single address phase: start edge is also the last phase
                            state_q   <= dispatch_state;
                            lat_q     <= LAT_LOAD;
                            data_oe_q <= dispatch_rd;
                            dv_oe_q   <= dispatch_rd;
                            dv_out_q  <= dispatch_rd;
                        end else begin
                            state_q <= S_ADDR;
                            phase_q <= PH_W'(1);
                        end
                    end
                end
                S_ADDR: begin
                    addr_q <= addr_shift;
                    if (phase_q == LAST_PH) begin
                        phase_q   <= '0;
                        state_q   <= dispatch_state;
                        lat_q     <= LAT_LOAD;
                        data_oe_q <= dispatch_rd;
                        dv_oe_q   <= dispatch_rd;
                        dv_out_q  <= dispatch_rd;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                S_RWAIT: begin
                    if (lat_q == 4'd0) begin
                        state_q   <= S_RDATA;
                        data_oe_q <= 1'b1;
                        dv_oe_q   <= 1'b1;
                        dv_out_q  <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                S_RDATA: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    if (beat_q == len_q) begin
                        state_q   <= S_IDLE;
                        beat_q    <= '0;
                        busy_q    <= 1'b0;
                        data_oe_q <= 1'b0;
                        dv_oe_q   <= 1'b0;
                        dv_out_q  <= 1'b0;
                    end else begin
                        beat_q <= beat_q + BURST_W'(1);
                    end
                end
                S_WDATA: begin
                    if (dv_in) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (beat_q == len_q) begin
                            state_q <= S_IDLE;
                            beat_q  <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            beat_q <= beat_q + BURST_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_q] <= data_in;
        end
    end

    assign data_out = data_oe_q ? mem_q[addr_q] : '0;
    assign data_oe  = data_oe_q;
    assign dv_oe    = dv_oe_q;
    assign dv_out   = dv_out_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_simplebus_burst_follower.sv
// Directed bench for simplebus_burst_follower: a default 8/16-bit instance
// (two address phases, two wait states) and an 8/8-bit instance with no wait states.
module tb_simplebus_burst_follower;

    localparam int RL_MAIN = 2;
    localparam int RL_8    = 0;

    logic       clk;
    logic       rst;

    logic       start, rd, dvin;
    logic [7:0] ab, din, dout;
    logic [1:0] blen;
    logic       doe, dvo, dvoe, busy;

    logic       start8, rd8, dvin8;
    logic [7:0] ab8, din8, dout8;
    logic [1:0] blen8;
    logic       doe8, dvo8, dvoe8, busy8;

    logic       cur_sel;
    logic       o_dv, o_doe, o_dvoe, o_busy;
    logic [7:0] o_dout;

    int total;
    int bad;

    simplebus_burst_follower #(
        .BUS_WIDTH(8), .ADDR_WIDTH(16), .READ_LATENCY(RL_MAIN), .BURST_W(2)
    ) dut (
        .clock(clk), .reset(rst), .start(start), .read(rd), .address(ab),
        .burst_len(blen), .data_in(din), .dv_in(dvin), .data_out(dout),
        .data_oe(doe), .dv_out(dvo), .dv_oe(dvoe), .busy(busy)
    );

    simplebus_burst_follower #(
        .BUS_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(RL_8), .BURST_W(2)
    ) dut8 (
        .clock(clk), .reset(rst), .start(start8), .read(rd8), .address(ab8),
        .burst_len(blen8), .data_in(din8), .dv_in(dvin8), .data_out(dout8),
        .data_oe(doe8), .dv_out(dvo8), .dv_oe(dvoe8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign o_dv   = cur_sel ? dvo8  : dvo;
    assign o_doe  = cur_sel ? doe8  : doe;
    assign o_dvoe = cur_sel ? dvoe8 : dvoe;
    assign o_busy = cur_sel ? busy8 : busy;
    assign o_dout = cur_sel ? dout8 : dout;

    typedef struct {
        bit          is_rd;
        logic [15:0] a;
        logic [1:0]  len;
        logic [31:0] d;     // beat i in bits [8*i +: 8]
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_start();
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic set_dv(input bit v, input logic [7:0] d);
        if (cur_sel) begin
            dvin8 = v;
            din8  = d;
        end else begin
            dvin = v;
            din  = d;
        end
    endtask

    // Drives all address phases; returns at the negedge of the last phase
    task automatic phases(input bit sel, input logic [15:0] a, input logic [1:0] len, input bit r);
        cur_sel = sel;
        @(negedge clk);
        if (sel) begin
            start8 = 1'b1;
            ab8    = a[7:0];
            blen8  = len;
            rd8    = r;
        end else begin
            start = 1'b1;
            ab    = a[15:8];
            blen  = len;
            rd    = r;
            @(negedge clk);
            start = 1'b0;
            ab    = a[7:0];
        end
    endtask

    task automatic do_write(input bit sel, input logic [15:0] a, input logic [1:0] len,
                            input logic [31:0] data, input int stall);
        phases(sel, a, len, 1'b0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            idle_start();
            set_dv(1'b0, 8'h77);
            check("stall_busy", {31'b0, o_busy}, 32'd1);
            check("stall_dv_oe", {31'b0, o_dvoe}, 32'd0);
        end
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            idle_start();
            set_dv(1'b1, data[8*i +: 8]);
        end
        @(negedge clk);
        set_dv(1'b0, 8'h00);
        check("wr_done_busy", {31'b0, o_busy}, 32'd0);
    endtask

    // Counts quiet cycles after the last address phase until dv_out appears
    task automatic wait_first(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            idle_start();
            if (o_dv) begin
                got = 1'b1;
            end else begin
                check("rwait_quiet", {31'b0, o_doe | o_dvoe}, 32'd0);
                n++;
            end
        end
        check("rd_first_beat", {31'b0, got}, 32'd1);
    endtask

    task automatic do_read(input bit sel, input logic [15:0] a, input logic [1:0] len,
                           input logic [31:0] exp, input bit poke);
        int n;
        bit got;
        phases(sel, a, len, 1'b1);
        wait_first(n, got);
        // quiet cycles equal READ_LATENCY: leader samples the first beat NPH+READ_LATENCY edges after start
        check("rd_latency", n, sel ? RL_8 : RL_MAIN);
        if (got) begin
            for (int i = 0; i <= int'(len); i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    idle_start();
                end
                check("rd_strobes", {29'b0, o_dv, o_doe, o_dvoe}, 32'd7);
                check("rd_data", {24'b0, o_dout}, {24'b0, exp[8*i +: 8]});
                if (poke && i == 0) begin
                    start8 = 1'b1;
                    ab8    = 8'h10;
                    rd8    = 1'b1;
                end
            end
            @(negedge clk);
            idle_start();
            check("rd_end_busy", {31'b0, o_busy}, 32'd0);
            check("rd_end_oe", {30'b0, o_doe, o_dvoe}, 32'd0);
            if (poke) begin
                @(negedge clk);
                check("start_ignored", {31'b0, o_busy}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        total = 0;
        bad   = 0;
        cur_sel = 1'b0;
        {start, rd, dvin, ab, din, blen} = '0;
        {start8, rd8, dvin8, ab8, din8, blen8} = '0;

        vecs[0]  = '{1'b0, 16'h0406, 2'd0, 32'h000000DC};
        vecs[1]  = '{1'b1, 16'h0406, 2'd0, 32'h000000DC};
        vecs[2]  = '{1'b0, 16'h0010, 2'd3, 32'hA3A2A1A0};
        vecs[3]  = '{1'b1, 16'h0010, 2'd3, 32'hA3A2A1A0};
        vecs[4]  = '{1'b0, 16'hFFFF, 2'd1, 32'h00002211};
        vecs[5]  = '{1'b1, 16'hFFFF, 2'd1, 32'h00002211};
        vecs[6]  = '{1'b1, 16'h0000, 2'd0, 32'h00000022};
        vecs[7]  = '{1'b1, 16'h0012, 2'd1, 32'h0000A3A2};
        vecs[8]  = '{1'b0, 16'h0202, 2'd0, 32'h00000033};
        vecs[9]  = '{1'b0, 16'h0300, 2'd0, 32'h00000044};
        vecs[10] = '{1'b0, 16'h1234, 2'd2, 32'h003CA55A};
        vecs[11] = '{1'b1, 16'h1234, 2'd2, 32'h003CA55A};
        vecs[12] = '{1'b1, 16'h0406, 2'd0, 32'h000000DC};

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_main_ctl", {28'b0, doe, dvo, dvoe, busy}, 32'd0);
        check("rst_main_data", {24'b0, dout}, 32'd0);
        check("rst_8_ctl", {28'b0, doe8, dvo8, dvoe8, busy8}, 32'd0);
        check("rst_8_data", {24'b0, dout8}, 32'd0);
        rst = 1'b0;

        // table-driven single/burst/wrap transactions
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].is_rd)
                do_read(1'b0, vecs[v].a, vecs[v].len, vecs[v].d, 1'b0);
            else
                do_write(1'b0, vecs[v].a, vecs[v].len, vecs[v].d, 0);
        end

        // stalled write: dv_in low for 5 cycles, nothing lands and the beat count holds
        do_write(1'b0, 16'h0200, 2'd1, 32'h00006F5E, 5);
        do_read(1'b0, 16'h0200, 2'd2, 32'h00336F5E, 1'b0);

        // reset during the second beat of a 4-beat read
        phases(1'b0, 16'h0010, 2'd3, 1'b1);
        wait_first(n, got);
        check("mid_beat0", {24'b0, dout}, 32'hA0);
        @(negedge clk);
        check("mid_beat1", {24'b0, dout}, 32'hA1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ctl", {28'b0, doe, dvo, dvoe, busy}, 32'd0);
        check("mid_rst_data", {24'b0, dout}, 32'd0);
        do_read(1'b0, 16'h0010, 2'd3, 32'hA3A2A1A0, 1'b0);

        // write beat coinciding with the reset edge is discarded
        phases(1'b0, 16'h0300, 2'd0, 1'b0);
        @(negedge clk);
        dvin = 1'b1;
        din  = 8'hEE;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        dvin = 1'b0;
        check("wr_rst_busy", {31'b0, busy}, 32'd0);
        do_read(1'b0, 16'h0300, 2'd0, 32'h00000044, 1'b0);

        // single address phase, zero wait states, start while busy ignored, wrap at 0xFF
        do_write(1'b1, 16'h007F, 2'd1, 32'h0000C2C1, 0);
        do_read(1'b1, 16'h007F, 2'd1, 32'h0000C2C1, 1'b1);
        do_write(1'b1, 16'h00FF, 2'd1, 32'h0000D2D1, 0);
        do_read(1'b1, 16'h0000, 2'd0, 32'h000000D2, 1'b0);
        do_read(1'b1, 16'h00FF, 2'd0, 32'h000000D1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
